mdu: RTL and testbench

- Multi-cycle multiply/divide unit in stage E, alongside the ALU. Operands come from the E-stage forwarded register values.
- Holds the architectural HI/LO registers. Their contents are read by E-stage MFHI/MFLO and carried down the E/M pipeline register.
- Exposes busy so the hazard unit stalls D/E while an operation is in flight.

---
 rtl/mdu.sv | 135 +++++++++++++
 tb/tb_mdu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit for stage E.
// Holds HI/LO; busy stalls D/E while an operation is in flight.
module mdu #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0]   pend, pend_n;
    logic          dz, dz_n;
    logic          done_n;
    logic [31:0]   hi_n, lo_n;

    logic        sgn;
    logic        a_neg, b_neg;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] ua, ub, ub_safe;
    logic [31:0] q_mag, r_mag, quo, rem;

    assign sgn   = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
    assign a_neg = sgn & A[31];
    assign b_neg = sgn & B[31];

    // Sign-extended 64x64 product keeps the low 64 bits exact for both signednesses
    assign mul_a = {{32{a_neg}}, A};
    assign mul_b = {{32{b_neg}}, B};
    assign prod  = mul_a * mul_b;

    // Divide on magnitudes so 0x80000000 / -1 wraps instead of overflowing
    assign ua      = a_neg ? (32'd0 - A) : A;
    assign ub      = b_neg ? (32'd0 - B) : B;
    assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
    assign q_mag   = ua / ub_safe;
    assign r_mag   = ua % ub_safe;
    assign quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    assign busy = (state == S_BUSY);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        dz_n    = dz;
        hi_n    = HI;
        lo_n    = LO;
        done_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU: begin
                            pend_n  = prod;
                            dz_n    = 1'b0;
                            cnt_n   = MUL_LAST;
                            state_n = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_n  = {rem, quo};
                            dz_n    = (B == 32'd0);
                            cnt_n   = DIV_LAST;
                            state_n = S_BUSY;
                        end
                        OP_MTHI: hi_n = A;
                        OP_MTLO: lo_n = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    if (!dz) begin
                        hi_n = pend[63:32];
                        lo_n = pend[31:0];
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= '0;
            dz    <= 1'b0;
            done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
            dz    <= dz_n;
            done  <= done_n;
            HI    <= hi_n;
            LO    <= lo_n;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: vector table plus hand-written corner sequences,
// with a done-driven scoreboard for committed HI/LO.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks;
    int errors;
    int done_cnt;
    logic [63:0] sb[$];
    logic [31:0] m_hi, m_lo;

    mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mdu_op(mdu_op),
        .A(A),
        .B(B),
        .busy(busy),
        .done(done),
        .HI(HI),
        .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse pops the oldest expected {HI,LO}
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got done=1 expected no commit");
            end else begin
                chk("sb_hilo", {HI, LO}, sb.pop_front());
            end
        end
    end

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] hi, input logic [31:0] lo);
        int n;
        start  = 1'b1;
        mdu_op = op;
        A      = a;
        B      = b;
        if (lat > 0) sb.push_back({hi, lo});
        @(posedge clk);
        #1;
        start = 1'b0;
        if (lat == 0) begin
            chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
            chk({nm, "_done"}, {63'd0, done}, 64'd0);
            chk({nm, "_hilo"}, {HI, LO}, {hi, lo});
        end else begin
            chk({nm, "_hold"}, {HI, LO}, {m_hi, m_lo});
            n = 0;
            while (busy && n < 40) begin
                n++;
                @(posedge clk);
                #1;
            end
            chk({nm, "_lat"}, 64'(n), 64'(lat));
            chk({nm, "_done"}, {63'd0, done}, 64'd1);
            @(posedge clk);
            #1;
            chk({nm, "_done_clr"}, {63'd0, done}, 64'd0);
        end
        m_hi = hi;
        m_lo = lo;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int d0;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        m_hi = '0;
        m_lo = '0;
        reset = 1'b0;
        start = 1'b0;
        mdu_op = '0;
        A = '0;
        B = '0;

        tv[0]  = '{3'd0, 32'd3,        32'hFFFFFFFE, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        tv[1]  = '{3'd1, 32'd3,        32'hFFFFFFFE, 5,  32'h00000002, 32'hFFFFFFFA};
        tv[2]  = '{3'd3, 32'd7,        32'd2,        10, 32'd1,        32'd3};
        tv[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tv[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000};
        tv[5]  = '{3'd4, 32'h1234,     32'd0,        0,  32'h1234,     32'h80000000};
        tv[6]  = '{3'd5, 32'h5678,     32'd0,        0,  32'h1234,     32'h5678};
        tv[7]  = '{3'd2, 32'd5,        32'd0,        10, 32'h1234,     32'h5678};
        tv[8]  = '{3'd6, 32'hFFFF,     32'd1,        0,  32'h1234,     32'h5678};
        tv[9]  = '{3'd0, 32'h7FFFFFFF, 32'h80000000, 5,  32'hC0000000, 32'h80000000};
        tv[10] = '{3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'd3};

        #1 reset = 1'b1;
        #1;
        chk("rst_state", {busy, done, HI, LO}, 66'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op("mthi_pre", 3'd4, 32'hAAAA, 32'd0, 0, 32'hAAAA, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_hi", {32'd0, HI}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // MULT 2*3 aborted by reset two cycles in; no commit may follow
        start = 1'b1;
        mdu_op = 3'd0;
        A = 32'd2;
        B = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        chk("abort_busy_on", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        #2 reset = 1'b1;
        #1;
        chk("abort_busy_off", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_hilo", {HI, LO}, 64'd0);
        chk("abort_idle", {62'd0, busy, done}, 64'd0);
        m_hi = '0;
        m_lo = '0;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("tv%0d", i), tv[i].op, tv[i].a, tv[i].b,
                   tv[i].lat, tv[i].hi, tv[i].lo);
        end

        // MTLO held on start during a MULT: ignored until busy falls
        start = 1'b1;
        mdu_op = 3'd0;
        A = 32'd4;
        B = 32'd5;
        sb.push_back({32'd0, 32'd20});
        @(posedge clk);
        #1;
        mdu_op = 3'd5;
        A = 32'hDEAD;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("hold_lat", 64'(n), 64'd5);
        chk("hold_lo20", {HI, LO}, {32'd0, 32'd20});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hold_mtlo", {HI, LO}, {32'd0, 32'hDEAD});
        chk("hold_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;

        // MULTU then DIVU accepted on the edge right after busy falls
        d0 = done_cnt;
        start = 1'b1;
        mdu_op = 3'd1;
        A = 32'hFFFFFFFF;
        B = 32'hFFFFFFFF;
        sb.push_back({32'hFFFFFFFE, 32'h00000001});
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("b2b_lat1", 64'(n), 64'd5);
        chk("b2b_hilo1", {HI, LO}, {32'hFFFFFFFE, 32'h00000001});
        start = 1'b1;
        mdu_op = 3'd3;
        A = 32'd100;
        B = 32'd7;
        sb.push_back({32'd2, 32'd14});
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("b2b_lat2", 64'(n), 64'd10);
        chk("b2b_hilo2", {HI, LO}, {32'd2, 32'd14});
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_dones", 64'(done_cnt - d0), 64'd2);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
